// File: rtl/kp_scan_ctrl.sv
// Keypad scan controller: column drive, row sync/debounce,
// one key code per press on a valid/ready output.
module kp_scan_ctrl #(
  parameter int SETTLE_CYC   = 4,
  parameter int DEBOUNCE_CNT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overrun
);
  localparam int CMAX = (SETTLE_CYC > DEBOUNCE_CNT) ?
                        SETTLE_CYC : DEBOUNCE_CNT;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CMAX);

  typedef enum logic [2:0] {
    SETTLE, SCAN, DEBOUNCE, HELD, REL_DEB
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]  kpc_q, kpc_d, kpc_rot;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  s1_q, s2_q;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        down_q, down_d;
  logic        ovr_q, ovr_d;
  logic        accept;
  logic        rows_idle;
  logic        one_low;

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd3;
    if (!v[3])      r = 2'd0;
    else if (!v[2]) r = 2'd1;
    else if (!v[1]) r = 2'd2;
    return r;
  endfunction

  assign rows_idle = (s2_q == 4'b1111);
  assign one_low   = (s2_q == 4'b0111) || (s2_q == 4'b1011) ||
                     (s2_q == 4'b1101) || (s2_q == 4'b1110);
  assign kpc_rot   = {kpc_q[0], kpc_q[3:1]};
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kpc_d   = kpc_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = valid_q;
    down_d  = down_q;
    ovr_d   = 1'b0;
    accept  = 1'b0;
    if (valid_q && key_ready) valid_d = 1'b0;
    unique case (state_q)
      SETTLE: begin
        if (cnt_q >= SET_LAST) begin
          state_d = SCAN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SCAN: begin
        if (rows_idle) begin
          kpc_d   = kpc_rot;
          cnt_d   = '0;
          state_d = SETTLE;
        end else if (one_low) begin
          cand_d  = s2_q;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (s2_q != cand_q) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else if (cnt_q >= DEB_LAST) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (rows_idle) begin
          cnt_d   = '0;
          state_d = REL_DEB;
        end
      end
      REL_DEB: begin
        if (!rows_idle) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q >= DEB_LAST) begin
          down_d  = 1'b0;
          kpc_d   = kpc_rot;
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SETTLE;
      end
    endcase
    // A press while the slot is still full is dropped, not queued.
    if (accept) begin
      down_d = 1'b1;
      if (!valid_q || key_ready) begin
        code_d  = {low_idx(cand_q), low_idx(kpc_q)};
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
      kpc_q   <= 4'b0111;
      cand_q  <= 4'b1111;
      s1_q    <= 4'b1111;
      s2_q    <= 4'b1111;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kpc_q   <= kpc_d;
      cand_q  <= cand_d;
      s1_q    <= kpr;
      s2_q    <= s1_q;
      code_q  <= code_d;
      valid_q <= valid_d;
      down_q  <= down_d;
      ovr_q   <= ovr_d;
    end
  end

  assign kpc       = kpc_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_kp_scan_ctrl.sv
// Bench for kp_scan_ctrl: keypad matrix model, vector table,
// corner-case sequences and a randomized press/consume scoreboard.
module tb_kp_scan_ctrl;
  logic       clk;
  logic       reset;
  logic [3:0] kpr;
  logic [3:0] kpc;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_down;
  logic       overrun;

  kp_scan_ctrl #(.SETTLE_CYC(2), .DEBOUNCE_CNT(4)) dut (
    .clk(clk), .reset(reset), .kpr(kpr), .kpc(kpc),
    .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .key_down(key_down),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Keypad matrix: a pressed key pulls its row low only while
  // its column is driven low.
  bit         pressed = 0;
  int         pr = 0;
  int         pc = 0;
  bit         use_ovr = 0;
  logic [3:0] kpr_ovr = 4'hF;

  always_comb begin
    kpr = 4'hF;
    if (use_ovr) kpr = kpr_ovr;
    else if (pressed && !kpc[3-pc]) kpr[3-pr] = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (key_valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_down(input bit val, input int budget,
                           output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (key_down == val) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] p;
    p = 4'b1111;
    p[3-c] = 1'b0;
    return p;
  endfunction

  // Scoreboard for the randomized phase.
  bit         mon_en = 0;
  int         rnd_ovr = 0;
  logic [3:0] exp_q[$];

  always @(posedge clk) begin
    if (mon_en) begin
      if (key_valid && key_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL rnd_extra: got %0h expected none", key_code);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (key_code == e) n_pass++;
          else $display("FAIL rnd_code: got %0h expected %0h",
                        key_code, e);
        end
      end
      if (overrun) rnd_ovr++;
    end
  end

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
  } vec_t;

  vec_t       tbl[8];
  logic [3:0] rot[4];
  bit         ok;
  bit         seen;
  bit         moved;
  int         cnt;
  logic [3:0] k0;

  initial begin
    tbl[0] = '{0, 0, 4'h0};
    tbl[1] = '{1, 1, 4'h5};
    tbl[2] = '{2, 3, 4'hB};
    tbl[3] = '{3, 2, 4'hE};
    tbl[4] = '{0, 3, 4'h3};
    tbl[5] = '{3, 0, 4'hC};
    tbl[6] = '{1, 2, 4'h6};
    tbl[7] = '{2, 1, 4'h9};
    rot[0] = 4'b0111;
    rot[1] = 4'b1011;
    rot[2] = 4'b1101;
    rot[3] = 4'b1110;

    reset = 1'b1;
    key_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state and column rotation, 3 cycles per column.
    chk("rst_kpc", kpc, 4'b0111);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_down", key_down, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("rot_%0d", i), kpc, rot[(i / 3) % 4]);
      @(negedge clk);
    end

    // Vector table: press, check code/hold, consume, release.
    for (int v = 0; v < 8; v++) begin
      pr = tbl[v].r;
      pc = tbl[v].c;
      pressed = 1;
      wait_valid(60, ok);
      chk($sformatf("v%0d_timeout", v), ok, 1'b1);
      chk($sformatf("v%0d_code", v), key_code, tbl[v].code);
      chk($sformatf("v%0d_down", v), key_down, 1'b1);
      cyc(5);
      chk($sformatf("v%0d_kpc", v), kpc, col_pat(tbl[v].c));
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      chk($sformatf("v%0d_consumed", v), key_valid, 1'b0);
      pressed = 0;
      wait_down(1'b0, 40, ok);
      chk($sformatf("v%0d_release", v), ok, 1'b1);
    end

    // Bouncing contact never reaches the debounce count.
    cyc(10);
    pr = 1;
    pc = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      pressed = ~pressed;
      repeat (2) begin
        @(negedge clk);
        if (key_valid) seen = 1;
      end
    end
    chk("bounce_no_valid", seen, 1'b0);
    pressed = 1;
    wait_valid(60, ok);
    chk("bounce_timeout", ok, 1'b1);
    chk("bounce_code", key_code, 4'h5);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (key_valid) cnt++;
      @(negedge clk);
    end
    chk("bounce_single", cnt, 0);
    pressed = 0;
    wait_down(1'b0, 40, ok);
    chk("bounce_release", ok, 1'b1);

    // Second press while the slot is full.
    pr = 0;
    pc = 0;
    pressed = 1;
    wait_valid(60, ok);
    chk("ovr_first_to", ok, 1'b1);
    chk("ovr_first_code", key_code, 4'h0);
    pressed = 0;
    wait_down(1'b0, 40, ok);
    chk("ovr_first_rel", ok, 1'b1);
    pc = 3;
    pressed = 1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (overrun) cnt++;
      @(negedge clk);
    end
    chk("ovr_pulses", cnt, 1);
    chk("ovr_down", key_down, 1'b1);
    chk("ovr_code_kept", key_code, 4'h0);
    chk("ovr_valid_kept", key_valid, 1'b1);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    chk("ovr_consumed", key_valid, 1'b0);
    pressed = 0;
    wait_down(1'b0, 40, ok);
    chk("ovr_release", ok, 1'b1);

    // Two rows low: no report and the column freezes.
    use_ovr = 1;
    kpr_ovr = 4'b0011;
    cyc(8);
    k0 = kpc;
    seen = 0;
    moved = 0;
    for (int i = 0; i < 20; i++) begin
      if (kpc != k0) moved = 1;
      if (key_valid) seen = 1;
      @(negedge clk);
    end
    chk("ghost_kpc_held", moved, 1'b0);
    chk("ghost_no_valid", seen, 1'b0);
    kpr_ovr = 4'hF;
    for (int i = 0; i < 12; i++) begin
      if (kpc != k0) moved = 1;
      @(negedge clk);
    end
    chk("ghost_resume", moved, 1'b1);
    use_ovr = 0;

    // Reset in HELD with an unconsumed key.
    pr = 2;
    pc = 2;
    pressed = 1;
    wait_valid(60, ok);
    chk("hrst_timeout", ok, 1'b1);
    chk("hrst_code", key_code, 4'hA);
    cyc(3);
    reset = 1'b1;
    @(negedge clk);
    chk("hrst_kpc", kpc, 4'b0111);
    chk("hrst_valid", key_valid, 1'b0);
    chk("hrst_down", key_down, 1'b0);
    chk("hrst_ovr", overrun, 1'b0);
    chk("hrst_code0", key_code, 4'h0);
    reset = 1'b0;
    pressed = 0;
    cyc(20);

    // Randomized presses with a random consumer.
    mon_en = 1;
    for (int n = 0; n < 12; n++) begin
      logic [1:0] r2;
      logic [1:0] c2;
      r2 = 2'($urandom_range(0, 3));
      c2 = 2'($urandom_range(0, 3));
      pr = int'(r2);
      pc = int'(c2);
      exp_q.push_back({r2, c2});
      pressed = 1;
      repeat (40 + $urandom_range(0, 20)) begin
        key_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      key_ready = 1'b1;
      pressed = 0;
      cyc(30 + $urandom_range(0, 20));
      chk($sformatf("rnd%0d_released", n), key_down, 1'b0);
    end
    cyc(5);
    mon_en = 0;
    key_ready = 1'b0;
    chk("rnd_all_consumed", exp_q.size(), 0);
    chk("rnd_no_overrun", rnd_ovr, 0);
    chk("rnd_idle_valid", key_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
